seq_detector_param: RTL and testbench

Parametrised, run-time programmable serial pattern detector; the successor to the fixed 0111110 detector in the serial receive path. It matches any pattern of 1..MAX_LEN bits and supports overlapping or non-overlapping match modes. Pattern, length and mode are loaded through a one-cycle config strobe. It reports match progress and, optionally, a saturating match count.

---
 rtl/seq_detector_param.sv | 111 +++++++++++
 tb/tb_seq_detector_param.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector (1..MAX_LEN bits, overlap/non-overlap).
// Optional saturating match counter is built when SEQ_DET_CNT_EN is defined.
module seq_detector_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0011_1110),
  parameter int                 RST_LEN = 7,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serin,
  input  logic               detect,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               serout,
  output logic [LEN_W-1:0]   state,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam logic [LEN_W:0]   MAX_LEN_X = (LEN_W + 1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;

  logic [LEN_W:0]     w_len_x;
  logic [LEN_W:0]     w_fill_x;
  logic               w_cfg_ok;
  logic               w_fill_ok;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic               w_serout;

  assign w_len_x   = {1'b0, r_len};
  assign w_fill_x  = {1'b0, r_fill};
  assign w_cfg_ok  = (r_len != '0) && (w_len_x <= MAX_LEN_X);
  // fill >= len-1, written without the subtraction so len=0 cannot underflow
  assign w_fill_ok = (w_fill_x + 1'b1) >= w_len_x;
  assign w_window  = {r_hist[MAX_LEN-2:0], serin};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = ((LEN_W + 1)'(i) < w_len_x);
    end
  end

  assign w_hit    = (((w_window ^ r_pat) & w_mask) == '0);
  assign w_serout = detect & w_cfg_ok & ~cfg_load & w_fill_ok & w_hit;
  assign serout   = w_serout;
  assign state    = r_fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= RST_PAT;
      r_len  <= LEN_W'(RST_LEN);
      r_ovl  <= 1'b0;
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= cfg_len;
      r_ovl  <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
    end else if (detect) begin
      r_hist <= {r_hist[MAX_LEN-2:0], serin};
      if (w_cfg_ok) begin
        if (w_serout && !r_ovl) begin
          r_fill <= '0;
        end else if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_serout && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_MAX - 1'b1) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus a randomized run against a bit-queue model.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               serin = 1'b0;
  logic               detect = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               serout;
  logic [LEN_W-1:0]   state;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  int total = 0;
  int bad   = 0;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .serin(serin), .detect(detect), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .serout(serout), .state(state), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  // Reference model: bits received since the last clear, plus match bookkeeping.
  logic [7:0] m_pat  = 8'b0011_1110;
  int         m_len  = 7;
  bit         m_ovl  = 1'b0;
  int         m_q[$];
  int         m_fill = 0;
  int         m_cnt  = 0;
  bit         m_sat  = 1'b0;

  bit obs_ser, exp_ser, obs_sat, exp_sat;
  int obs_state, exp_state, obs_cnt, exp_cnt;

  function automatic bit model_serout(bit det, bit ld, bit s);
    if (!det || ld || m_len < 1 || m_len > MAX_LEN) return 1'b0;
    if (m_fill < m_len - 1) return 1'b0;
    if (m_pat[0] != s) return 1'b0;
    for (int k = 1; k < m_len; k++) begin
      if (m_q[m_q.size() - k] != int'(m_pat[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(input bit r, input bit ld, input bit det, input bit s, input bit hit);
    if (r) begin
      m_pat = 8'b0011_1110; m_len = 7; m_ovl = 0;
      m_q.delete(); m_fill = 0; m_cnt = 0; m_sat = 0;
    end else if (ld) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      m_q.delete(); m_fill = 0; m_cnt = 0; m_sat = 0;
    end else if (det) begin
      m_q.push_back(int'(s));
      if (m_q.size() > 16) void'(m_q.pop_front());
      if (m_len >= 1 && m_len <= MAX_LEN) begin
        if (hit && !m_ovl) m_fill = 0;
        else if (m_fill < MAX_LEN) m_fill++;
      end
`ifdef SEQ_DET_CNT_EN
      if (hit) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_cnt == CNT_MAX) m_sat = 1'b1;
      end
`endif
    end
  endtask

  // Drives one cycle; serout is sampled before the edge, state/counter after it.
  task automatic step(input bit r, input bit ld, input bit det, input bit s);
    rst = r; cfg_load = ld; detect = det; serin = s;
    @(negedge clk);
    obs_ser = serout;
    exp_ser = model_serout(det, ld, s);
    obs_state = int'(state);
    @(posedge clk);
    model_update(r, ld, det, s, exp_ser);
    #1;
    exp_state = m_fill;
    exp_cnt   = m_cnt;
    exp_sat   = m_sat;
    obs_cnt   = int'(match_cnt);
    obs_sat   = cnt_sat;
    rst = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] p, input int l, input bit o);
    cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
    step(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    total++;
    if (state !== 4'd0 || match_cnt !== 2'd0 || cnt_sat !== 1'b0) begin
      bad++;
      $display("FAIL reset: state=%0d cnt=%0d sat=%0b, need 0/0/0", state, match_cnt, cnt_sat);
    end
    step(0, 0, 0, 1);
    total++;
    if (obs_ser !== 1'b0 || obs_state != 0) begin
      bad++;
      $display("FAIL reset_idle: serout=%0b state=%0d, need 0/0", obs_ser, obs_state);
    end
  endtask

  task automatic test_default_pattern();
    bit bits[7] = '{0, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, bits[i]);
      total++;
      if (obs_ser !== (i == 6) || obs_state != i) begin
        bad++;
        $display("FAIL default_bit%0d: serout=%0b state=%0d, need %0b/%0d", i + 1, obs_ser, obs_state, i == 6, i);
      end
    end
    total++;
    if (state !== 4'd0) begin
      bad++;
      $display("FAIL default_post: state=%0d, need 0", state);
    end
  endtask

  task automatic test_overlap(input bit ovl);
    bit bits[7] = '{1, 0, 1, 0, 1, 0, 1};
    bit need;
    load_cfg(8'b101, 3, ovl);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, bits[i]);
      need = ovl ? (i == 2 || i == 4 || i == 6) : (i == 2 || i == 6);
      total++;
      if (obs_ser !== need) begin
        bad++;
        $display("FAIL ovl%0b_bit%0d: serout=%0b, need %0b", ovl, i + 1, obs_ser, need);
      end
      if (!ovl && i == 2) begin
        total++;
        if (state !== 4'd0) begin
          bad++;
          $display("FAIL novl_state_after3: state=%0d, need 0", state);
        end
      end
    end
`ifdef SEQ_DET_CNT_EN
    total++;
    if (int'(match_cnt) != (ovl ? 3 : 2)) begin
      bad++;
      $display("FAIL ovl%0b_cnt: cnt=%0d, need %0d", ovl, match_cnt, ovl ? 3 : 2);
    end
`else
    total++;
    if (match_cnt !== 2'd0 || cnt_sat !== 1'b0) begin
      bad++;
      $display("FAIL cnt_tied: cnt=%0d sat=%0b, need 0/0", match_cnt, cnt_sat);
    end
`endif
  endtask

  task automatic test_detect_gap();
    load_cfg(8'b101, 3, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      total++;
      if (obs_ser !== 1'b0 || state !== 4'd2) begin
        bad++;
        $display("FAIL gap_hold%0d: serout=%0b state=%0d, need 0/2", i, obs_ser, state);
      end
    end
    step(0, 0, 1, 1);
    total++;
    if (obs_ser !== 1'b1) begin
      bad++;
      $display("FAIL gap_match: serout=%0b, need 1", obs_ser);
    end
  endtask

  task automatic test_cfg_abort();
    load_cfg(8'b101, 3, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 1, 1, 1);
    total++;
    if (obs_ser !== 1'b0 || state !== 4'd0) begin
      bad++;
      $display("FAIL abort: serout=%0b state=%0d, need 0/0", obs_ser, state);
    end
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    total++;
    if (obs_ser !== 1'b1) begin
      bad++;
      $display("FAIL abort_rematch: serout=%0b, need 1", obs_ser);
    end
  endtask

  task automatic test_count_sat();
    int need_cnt[5] = '{1, 2, 3, 3, 3};
    load_cfg(8'b1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1);
      total++;
`ifdef SEQ_DET_CNT_EN
      if (obs_ser !== 1'b1 || obs_cnt != need_cnt[i] || obs_sat !== (i >= 2)) begin
        bad++;
        $display("FAIL sat%0d: serout=%0b cnt=%0d sat=%0b, need 1/%0d/%0b", i, obs_ser, obs_cnt, obs_sat, need_cnt[i], i >= 2);
      end
`else
      if (obs_ser !== 1'b1 || obs_cnt != 0 || obs_sat !== 1'b0) begin
        bad++;
        $display("FAIL sat%0d: serout=%0b cnt=%0d sat=%0b, need 1/0/0", i, obs_ser, obs_cnt, obs_sat);
      end
`endif
    end
  endtask

  task automatic test_len_zero();
    load_cfg(8'h00, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1'($urandom_range(0, 1)));
      total++;
      if (obs_ser !== 1'b0 || state !== 4'd0) begin
        bad++;
        $display("FAIL len0_%0d: serout=%0b state=%0d, need 0/0", i, obs_ser, state);
      end
    end
  endtask

  task automatic test_random();
    bit r, ld, det, s;
    int l;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      det = ($urandom_range(0, 3) != 0);
      s   = 1'($urandom_range(0, 1));
      if (ld) begin
        l = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 4) : $urandom_range(0, 12);
        cfg_pattern = 8'($urandom);
        cfg_len     = LEN_W'(l);
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      step(r, ld, det, s);
      if (!r) begin
        total++;
        if (obs_ser !== exp_ser) begin
          bad++;
          $display("FAIL rand_serout@%0d: got %0b, need %0b", i, obs_ser, exp_ser);
        end
      end
      total++;
      if (int'(state) != exp_state || int'(match_cnt) != exp_cnt || cnt_sat !== exp_sat) begin
        bad++;
        $display("FAIL rand_regs@%0d: state=%0d cnt=%0d sat=%0b, need %0d/%0d/%0b",
                 i, state, match_cnt, cnt_sat, exp_state, exp_cnt, exp_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_overlap(1);
    test_overlap(0);
    test_detect_gap();
    test_cfg_abort();
    test_count_sat();
    test_len_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
